fifo_rd_framer: RTL and testbench

Read-side framer that sits directly downstream of the 4096×16-in / 32-out HSST test FIFO, in its read clock domain. It waits until the FIFO holds a full frame of 32-bit words, then pops exactly FRAME_LEN words and emits SOF + payload + EOF on a 32-bit 8b/10b TX data path with per-byte K flags. Between frames it emits comma/idle words, which keeps the HSST lane aligned.

---
 rtl/fifo_rd_framer.sv | 184 ++++++++++++++++++
 tb/tb_fifo_rd_framer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_framer.sv
// fifo_rd_framer
//   Read-side framer for the HSST test FIFO (32-bit read port). Waits for a
//   full frame of words to be available, pops exactly FRAME_LEN words and
//   emits SOF + payload + EOF on a 32-bit 8b/10b TX path with per-byte K
//   flags. Idle/comma words are sent between frames to keep the lane aligned.
//
//   Optional feature macro: FIFO_RD_FRAMER_CHECKSUM_EN
//     defined   -> EOF carries the 24-bit payload sum: {sum[23:0], 8'hFD}
//     undefined -> EOF is 32'h0000_00FD and no accumulator is built
//
// Ports
//   rd_clk              FIFO read clock (only clock)
//   rd_rst              synchronous active-high reset
//   tx_en               permission to start new frames (sampled in IDLE only)
//   fifo_rd_data        FIFO read data, valid 1 cycle after fifo_rd_en
//   fifo_rd_empty       FIFO empty flag
//   fifo_rd_water_level FIFO read-side fill level in words
//   fifo_rd_en          FIFO pop (combinational)
//   tx_data / tx_k      registered TX word and K flags (bit0 -> byte [7:0])
//   seq_num             sequence number of the next frame
//   frame_done          1-cycle pulse while EOF is on tx_data
//   underflow_err       sticky: a pop was needed while the FIFO was empty
//
// State     | meaning
// ST_IDLE   | idle words out; decision cycle pops word 0 and loads SOF
// ST_SOF    | SOF on tx_data; pops word 1, loads payload word 0
// ST_PAYLOAD| payload word cnt on tx_data; last index loads EOF
// ST_EOF    | EOF on tx_data, frame_done high; arms the gap counter
// ST_GAP    | idle words out until the gap counter expires

module fifo_rd_framer #(
  parameter int FRAME_LEN      = 64,
  parameter int IDLE_GAP       = 4,
  parameter int RD_LEVEL_WIDTH = 12
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      tx_en,
  input  logic [31:0]               fifo_rd_data,
  input  logic                      fifo_rd_empty,
  input  logic [RD_LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                      fifo_rd_en,
  output logic [31:0]               tx_data,
  output logic [3:0]                tx_k,
  output logic [7:0]                seq_num,
  output logic                      frame_done,
  output logic                      underflow_err
);

  localparam logic [31:0] IDLE_WORD   = 32'h50BC_50BC;
  localparam logic [3:0]  IDLE_K      = 4'b0101;
  localparam logic [3:0]  CTRL_K      = 4'b0001;
  localparam logic [7:0]  FRAME_LEN_8 = 8'(FRAME_LEN);
  localparam logic [8:0]  FRAME_LEN_9 = 9'(FRAME_LEN);
  localparam logic [7:0]  LAST_IDX    = 8'(FRAME_LEN - 1);
  localparam logic [3:0]  GAP_LOAD    = 4'(IDLE_GAP - 1);
  localparam logic [RD_LEVEL_WIDTH-1:0] FRAME_LEVEL = RD_LEVEL_WIDTH'(FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_EOF,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        need_pop, start, load_pay, last_word;
  logic        miss_q;
  logic [31:0] pay_word, eof_word;
  logic [31:0] tx_data_d;
  logic [3:0]  tx_k_d;

  // A suppressed pop leaves stale data on the FIFO port; replace it with zero.
  assign pay_word = miss_q ? 32'h0000_0000 : fifo_rd_data;

`ifdef FIFO_RD_FRAMER_CHECKSUM_EN
  logic [23:0] sum_q;
  assign eof_word = {sum_q, 8'hFD};

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      sum_q <= '0;
    end else if (start) begin
      sum_q <= '0;
    end else if (load_pay) begin
      sum_q <= sum_q + pay_word[23:0];
    end
  end
`else
  assign eof_word = 32'h0000_00FD;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    need_pop  = 1'b0;
    start     = 1'b0;
    load_pay  = 1'b0;
    last_word = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_en && (fifo_rd_water_level >= FRAME_LEVEL) && !fifo_rd_empty &&
            (gap_q == 4'd0)) begin
          start    = 1'b1;
          need_pop = 1'b1;
          state_d  = ST_SOF;
        end
      end
      ST_SOF: begin
        need_pop = 1'b1;
        load_pay = 1'b1;
        cnt_d    = 8'd0;
        state_d  = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // Pops run two words ahead of the word currently on tx_data.
        need_pop = (({1'b0, cnt_q} + 9'd2) < FRAME_LEN_9);
        if (cnt_q == LAST_IDX) begin
          last_word = 1'b1;
          state_d   = ST_EOF;
        end else begin
          load_pay = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      ST_EOF: begin
        // The decision cycle itself is the last idle word of the gap.
        gap_d   = GAP_LOAD;
        state_d = (GAP_LOAD == 4'd0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q == 4'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_rd_en = need_pop & ~fifo_rd_empty & ~rd_rst;

  always_comb begin
    tx_data_d = IDLE_WORD;
    tx_k_d    = IDLE_K;
    if (start) begin
      tx_data_d = {seq_num, FRAME_LEN_8, 8'h00, 8'hFB};
      tx_k_d    = CTRL_K;
    end else if (load_pay) begin
      tx_data_d = pay_word;
      tx_k_d    = 4'b0000;
    end else if (last_word) begin
      tx_data_d = eof_word;
      tx_k_d    = CTRL_K;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      miss_q        <= 1'b0;
      tx_data       <= IDLE_WORD;
      tx_k          <= IDLE_K;
      seq_num       <= '0;
      frame_done    <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      miss_q        <= need_pop & fifo_rd_empty;
      tx_data       <= tx_data_d;
      tx_k          <= tx_k_d;
      frame_done    <= last_word;
      underflow_err <= underflow_err | (need_pop & fifo_rd_empty);
      if (last_word) seq_num <= seq_num + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_framer.sv
module tb_fifo_rd_framer;

  localparam int FL = 4;
  localparam int IG = 2;
  localparam logic [31:0] IDLE_W = 32'h50BC_50BC;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [31:0] fifo_rd_data = 32'h0;
  logic        fifo_rd_empty = 1'b1;
  logic [11:0] lvl = 12'd0;
  logic        fifo_rd_en;
  logic [31:0] tx_data;
  logic [3:0]  tx_k;
  logic [7:0]  seq_num;
  logic        frame_done;
  logic        underflow_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];
  int rd_ptr = 0;

  fifo_rd_framer #(.FRAME_LEN(FL), .IDLE_GAP(IG), .RD_LEVEL_WIDTH(12)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .tx_en(tx_en),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(lvl), .fifo_rd_en(fifo_rd_en),
    .tx_data(tx_data), .tx_k(tx_k), .seq_num(seq_num),
    .frame_done(frame_done), .underflow_err(underflow_err)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO read port model: one cycle read latency.
  always @(posedge rd_clk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= (rd_ptr + 1) % 4096;
    end
  end

  function automatic logic [31:0] eof_of(input logic [23:0] s);
`ifdef FIFO_RD_FRAMER_CHECKSUM_EN
    return {s, 8'hFD};
`else
    return 32'h0000_00FD;
`endif
  endfunction

  task automatic do_reset;
    @(negedge rd_clk);
    rd_rst = 1'b1; tx_en = 1'b0; lvl = 12'd0; fifo_rd_empty = 1'b0;
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  task automatic test_reset;
    rd_rst = 1'b1; tx_en = 1'b1; lvl = 12'd4; fifo_rd_empty = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (tx_data !== IDLE_W) begin errors++; $display("FAIL reset_tx_data: got %h expected %h", tx_data, IDLE_W); end
    checks++; if (tx_k !== 4'b0101) begin errors++; $display("FAIL reset_tx_k: got %b expected 0101", tx_k); end
    checks++; if (seq_num !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", seq_num); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow_err); end
    lvl = 12'd0; rd_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rd_clk); #1;
      checks++;
      if (tx_data !== IDLE_W || tx_k !== 4'b0101 || fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_level0 cyc %0d: got data %h k %b rd_en %b expected %h 0101 0", c, tx_data, tx_k, fifo_rd_en, IDLE_W);
      end
    end
  endtask

  task automatic test_single_frame;
    int pops, dones;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    for (int i = 0; i < FL; i++) mem[(rd_ptr + i) % 4096] = 32'(i + 1);
    @(negedge rd_clk);
    tx_en = 1'b1; lvl = 12'd4; fifo_rd_empty = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL frame_decision_rd_en: got %b expected 1", fifo_rd_en); end
    pops = (fifo_rd_en === 1'b1) ? 1 : 0;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge rd_clk);
      if (c == 1) tx_en = 1'b0;
      #1;
      if (fifo_rd_en === 1'b1) pops++;
      if (frame_done === 1'b1) dones++;
      if (c == 1) begin exp_d = 32'h0004_00FB; exp_k = 4'b0001; end
      else if (c <= 5) begin exp_d = 32'(c - 1); exp_k = 4'b0000; end
      else if (c == 6) begin exp_d = eof_of(24'h00000A); exp_k = 4'b0001; end
      else begin exp_d = IDLE_W; exp_k = 4'b0101; end
      checks++;
      if (tx_data !== exp_d || tx_k !== exp_k) begin
        errors++;
        $display("FAIL frame_word c%0d: got %h/%b expected %h/%b", c, tx_data, tx_k, exp_d, exp_k);
      end
      if (c == 6) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_at_eof: got %b expected 1", frame_done); end
      end
    end
    checks++; if (pops != FL) begin errors++; $display("FAIL frame_pop_count: got %0d expected %0d", pops, FL); end
    checks++; if (dones != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", dones); end
    checks++; if (seq_num !== 8'd1) begin errors++; $display("FAIL frame_seq_after: got %0d expected 1", seq_num); end
  endtask

  task automatic test_level_threshold;
    for (int i = 0; i < FL; i++) mem[(rd_ptr + i) % 4096] = 32'hA0 + 32'(i);
    @(negedge rd_clk);
    tx_en = 1'b1; lvl = 12'd3; fifo_rd_empty = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || tx_data !== IDLE_W) begin
        errors++;
        $display("FAIL level3_no_start cyc %0d: got rd_en %b data %h expected 0 %h", c, fifo_rd_en, tx_data, IDLE_W);
      end
      @(negedge rd_clk);
    end
    lvl = 12'd4;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL level4_start: got %b expected 1", fifo_rd_en); end
    @(negedge rd_clk);
    tx_en = 1'b0;
    #1;
    checks++; if (tx_data !== 32'h0104_00FB) begin errors++; $display("FAIL level4_sof: got %h expected 010400fb", tx_data); end
    repeat (11) @(negedge rd_clk);
    #1;
    checks++; if (seq_num !== 8'd2) begin errors++; $display("FAIL level_seq_after: got %0d expected 2", seq_num); end
  endtask

  task automatic test_underflow;
    int pops;
    logic [31:0] exp_d;
    do_reset();
    mem[rd_ptr % 4096]       = 32'h11;
    mem[(rd_ptr + 1) % 4096] = 32'h22;
    mem[(rd_ptr + 2) % 4096] = 32'h33;
    mem[(rd_ptr + 3) % 4096] = 32'h44;
    tx_en = 1'b1; lvl = 12'd4; fifo_rd_empty = 1'b0;
    #1;
    pops = (fifo_rd_en === 1'b1) ? 1 : 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge rd_clk);
      if (c == 1) tx_en = 1'b0;
      if (c == 2) fifo_rd_empty = 1'b1;
      if (c == 3) fifo_rd_empty = 1'b0;
      #1;
      if (fifo_rd_en === 1'b1) pops++;
      if (c == 2) begin
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL uf_pop_suppressed: got %b expected 0", fifo_rd_en); end
      end
      case (c)
        1: exp_d = 32'h0004_00FB;
        2: exp_d = 32'h11;
        3: exp_d = 32'h22;
        4: exp_d = 32'h0;
        5: exp_d = 32'h33;
        6: exp_d = eof_of(24'h000066);
        default: exp_d = IDLE_W;
      endcase
      checks++;
      if (tx_data !== exp_d) begin errors++; $display("FAIL uf_word c%0d: got %h expected %h", c, tx_data, exp_d); end
      if (c == 6) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL uf_eof_nominal: got frame_done %b expected 1", frame_done); end
      end
      checks++;
      if (underflow_err !== (c >= 3)) begin
        errors++; $display("FAIL uf_flag c%0d: got %b expected %b", c, underflow_err, (c >= 3));
      end
    end
    checks++; if (pops != 3) begin errors++; $display("FAIL uf_pop_count: got %0d expected 3", pops); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < FL; i++) mem[(rd_ptr + i) % 4096] = 32'hC0 + 32'(i);
    @(negedge rd_clk);
    tx_en = 1'b1; lvl = 12'd4; fifo_rd_empty = 1'b0;
    @(negedge rd_clk);
    tx_en = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    #1;
    checks++; if (tx_data !== 32'hC1) begin errors++; $display("FAIL mid_word2: got %h expected c1", tx_data); end
    rd_rst = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en: got %b expected 0", fifo_rd_en); end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    #1;
    checks++; if (tx_data !== IDLE_W || tx_k !== 4'b0101) begin errors++; $display("FAIL mid_rst_idle: got %h/%b expected %h/0101", tx_data, tx_k, IDLE_W); end
    checks++; if (seq_num !== 8'd0) begin errors++; $display("FAIL mid_rst_seq: got %0d expected 0", seq_num); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL mid_rst_uf: got %b expected 0", underflow_err); end
    for (int c = 0; c < 8; c++) begin
      @(negedge rd_clk); #1;
      checks++;
      if (tx_data !== IDLE_W || frame_done !== 1'b0 || fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_no_eof cyc %0d: got %h fd %b rd_en %b expected %h 0 0", c, tx_data, frame_done, fifo_rd_en, IDLE_W);
      end
    end
  endtask

  task automatic test_back_to_back;
    int sofs, idles;
    logic [7:0] exp_seq;
    logic [31:0] exp_sof;
    do_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    tx_en = 1'b1; lvl = 12'd4; fifo_rd_empty = 1'b0;
    sofs = 0; idles = 0; exp_seq = 8'd0;
    for (int c = 0; c < 2400 && sofs < 258; c++) begin
      @(negedge rd_clk); #1;
      if (tx_k === 4'b0001 && tx_data[7:0] === 8'hFB) begin
        exp_sof = {exp_seq, 8'h04, 8'h00, 8'hFB};
        checks++;
        if (tx_data !== exp_sof) begin errors++; $display("FAIL b2b_sof #%0d: got %h expected %h", sofs, tx_data, exp_sof); end
        if (sofs > 0) begin
          checks++;
          if (idles != IG) begin errors++; $display("FAIL b2b_gap #%0d: got %0d idle words expected %0d", sofs, idles, IG); end
        end
        if (sofs == 256) begin
          checks++;
          if (tx_data[31:24] !== 8'd0) begin errors++; $display("FAIL b2b_wrap: got %0d expected 0", tx_data[31:24]); end
        end
        sofs++;
        exp_seq = exp_seq + 8'd1;
      end else if (tx_k === 4'b0001 && tx_data[7:0] === 8'hFD) begin
        idles = 0;
      end else if (tx_data === IDLE_W && tx_k === 4'b0101) begin
        idles++;
      end
    end
    checks++;
    if (sofs != 258) begin errors++; $display("FAIL b2b_timeout: got %0d frames expected 258", sofs); end
    @(negedge rd_clk);
    tx_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_level_threshold();
    test_underflow();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
